multi_channel_light_timer: RTL and testbench

Parametrised successor to the single-duration light timer. Serves NUM_CH independent signal-head channels. Each channel times one of three phases (green, yellow, all-red clearance), with durations held in a runtime-writable table. The block also supports retrigger, per-channel abort, a global pause and a remaining-count readout. It sits between the intersection phase controller (start/mode/abort) and the configuration interface (duration writes).

---
 rtl/multi_channel_light_timer.sv | 138 +++++++++++++
 tb/tb_multi_channel_light_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_light_timer.sv
// Multi-channel signal-head phase timer: NUM_CH independent countdown channels
// whose green/yellow/clearance durations come from a runtime-writable table.
module multi_channel_light_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 15,
  parameter int GREEN_DEF  = 5,
  parameter int YELLOW_DEF = 3,
  parameter int CLEAR_DEF  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       abort,
  input  logic                    pause,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_val,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err,
  output logic [CNT_W*NUM_CH-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_INV = 2'd3;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] rem_q   [NUM_CH];
  logic [CNT_W-1:0] rem_d   [NUM_CH];
  logic [CNT_W-1:0] dur_q   [NUM_CH][3];
  logic [CNT_W-1:0] dur_d   [NUM_CH][3];
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q,  err_d;

  function automatic logic [CNT_W-1:0] dur_default(input int m);
    case (m)
      0:       return CNT_W'(GREEN_DEF);
      1:       return CNT_W'(YELLOW_DEF);
      default: return CNT_W'(CLEAR_DEF);
    endcase
  endfunction

  // Matching on the full 4-bit index and on m in 0..2 drops out-of-range
  // channels and phase 3 without any explicit guard.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int m = 0; m < 3; m++) begin
        dur_d[c][m] = dur_q[c][m];
        if (cfg_we && cfg_ch == 4'(c) && cfg_mode == 2'(m)) dur_d[c][m] = cfg_val;
      end
    end
  end

  always_comb begin
    logic [1:0]       m;
    logic [CNT_W-1:0] d;
    m = '0;
    d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      rem_d[k]   = rem_q[k];
      done_d[k]  = 1'b0;
      err_d[k]   = 1'b0;
      m          = mode[2*k +: 2];
      d          = '0;
      // Starts read the registered table, so a same-cycle write is not yet seen.
      for (int j = 0; j < 3; j++) begin
        if (m == 2'(j)) d = dur_q[k][j];
      end

      if (abort[k]) begin
        state_d[k] = IDLE;
        rem_d[k]   = '0;
      end else begin
        if (start[k] && m == MODE_INV) err_d[k] = 1'b1;

        if (start[k] && m != MODE_INV) begin
          if (d == '0) begin
            state_d[k] = IDLE;
            rem_d[k]   = '0;
            done_d[k]  = 1'b1;
          end else begin
            state_d[k] = RUN;
            rem_d[k]   = d;
          end
        end else if (state_q[k] == RUN && !pause) begin
          if (rem_q[k] <= CNT_W'(1)) begin
            state_d[k] = IDLE;
            rem_d[k]   = '0;
            done_d[k]  = 1'b1;
          end else begin
            rem_d[k] = rem_q[k] - CNT_W'(1);
          end
        end
      end
    end
  end

  // NOTE: the duration table is state that must return to its defaults on reset,
  // so unlike a plain storage array it sits inside the reset branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        rem_q[k]   <= '0;
        for (int m = 0; m < 3; m++) dur_q[k][m] <= dur_default(m);
      end
      done_q <= '0;
      err_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values.
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        rem_q[k]   <= rem_d[k];
        for (int m = 0; m < 3; m++) dur_q[k][m] <= dur_d[k][m];
      end
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      busy[k]                      = (state_q[k] == RUN);
      remaining[k*CNT_W +: CNT_W]  = rem_q[k];
    end
    done = done_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_multi_channel_light_timer.sv
// Directed bench for multi_channel_light_timer: a vector table for the main
// behaviours plus hand-written pause and asynchronous-reset sequences.
module tb_multi_channel_light_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 15;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       start;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       abort;
  logic                    pause;
  logic                    cfg_we;
  logic [3:0]              cfg_ch;
  logic [1:0]              cfg_mode;
  logic [CNT_W-1:0]        cfg_val;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       err;
  logic [CNT_W*NUM_CH-1:0] remaining;

  multi_channel_light_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GREEN_DEF(5), .YELLOW_DEF(3), .CLEAR_DEF(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .pause(pause), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_val(cfg_val), .busy(busy), .done(done), .err(err), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [7:0]  md;
    logic [3:0]  ab;
    logic        we;
    logic [3:0]  ch;
    logic [1:0]  cm;
    logic [14:0] val;
    logic [3:0]  eb;
    logic [3:0]  ed;
    logic [3:0]  ee;
    logic [59:0] er;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        pend_we  = 1'b0;
  logic [3:0]  pend_ch  = '0;
  logic [1:0]  pend_cm  = '0;
  logic [14:0] pend_val = '0;

  function automatic logic [7:0] md4(input int m3, input int m2, input int m1, input int m0);
    return {2'(m3), 2'(m2), 2'(m1), 2'(m0)};
  endfunction

  function automatic logic [59:0] rp(input int r3, input int r2, input int r1, input int r0);
    return {15'(r3), 15'(r2), 15'(r1), 15'(r0)};
  endfunction

  task automatic addw(input logic [3:0] ch, input logic [1:0] cm, input logic [14:0] val);
    pend_we  = 1'b1;
    pend_ch  = ch;
    pend_cm  = cm;
    pend_val = val;
  endtask

  task automatic add(input logic [3:0] st, input logic [7:0] md, input logic [3:0] ab,
                     input logic [3:0] eb, input logic [3:0] ed, input logic [3:0] ee,
                     input logic [59:0] er);
    vec_t v;
    v.st = st;  v.md = md;  v.ab = ab;
    v.we = pend_we;  v.ch = pend_ch;  v.cm = pend_cm;  v.val = pend_val;
    v.eb = eb;  v.ed = ed;  v.ee = ee;  v.er = er;
    vecs.push_back(v);
    pend_we = 1'b0;
  endtask

  task automatic check(input string name, input logic [3:0] eb, input logic [3:0] ed,
                       input logic [3:0] ee, input logic [59:0] er);
    n_vec++;
    if (busy !== eb || done !== ed || err !== ee || remaining !== er) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b err=%b rem=%h, want busy=%b done=%b err=%b rem=%h",
               name, busy, done, err, remaining, eb, ed, ee, er);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic [3:0] st, input logic [7:0] md, input logic [3:0] ab,
                     input logic pa);
    start = st;
    mode  = md;
    abort = ab;
    pause = pa;
    @(posedge clk);
    #1;
    start  = '0;
    mode   = '0;
    abort  = '0;
    pause  = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;  start = '0;  mode = '0;  abort = '0;  pause = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_val = '0;

    // Green count on ch0: 5,4,3,2,1 then done.
    add(4'b0001, md4(0,0,0,0), 4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,5));
    add(4'b0000, 8'h00,        4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,4));
    add(4'b0000, 8'h00,        4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,3));
    add(4'b0000, 8'h00,        4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,2));
    add(4'b0000, 8'h00,        4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,1));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    // ch2/yellow := 7; a write to nonexistent ch5 must not alias onto ch1.
    addw(4'd2, 2'd1, 15'd7);
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    addw(4'd5, 2'd2, 15'd9);
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    // ch1 clear (D=1) alongside ch2 yellow (D=7).
    add(4'b0110, md4(0,1,2,0), 4'b0000, 4'b0110, 4'b0000, 4'b0000, rp(0,7,1,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0010, 4'b0000, rp(0,6,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0000, 4'b0000, rp(0,5,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0000, 4'b0000, rp(0,4,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0000, 4'b0000, rp(0,3,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0000, 4'b0000, rp(0,2,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0100, 4'b0000, 4'b0000, rp(0,1,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0100, 4'b0000, rp(0,0,0,0));
    // Same-cycle write to ch3/green uses the old 5; the next start sees 2.
    addw(4'd3, 2'd0, 15'd2);
    add(4'b1000, md4(0,0,0,0), 4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(5,0,0,0));
    add(4'b0000, 8'h00,        4'b1000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    add(4'b1000, md4(0,0,0,0), 4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(2,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(1,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b1000, 4'b0000, rp(0,0,0,0));
    // Zero duration: done at once, never busy.
    addw(4'd0, 2'd2, 15'd0);
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    add(4'b0001, md4(0,0,0,2), 4'b0000, 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    // Retrigger ch3 at remaining=1 with yellow: no done, reload 3.
    add(4'b1000, md4(2,0,0,0), 4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(1,0,0,0));
    add(4'b1000, md4(1,0,0,0), 4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(3,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(2,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b1000, 4'b0000, 4'b0000, rp(1,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b1000, 4'b0000, rp(0,0,0,0));
    // Abort beats start on ch1; mode 3 raises err only.
    add(4'b0010, md4(0,0,0,0), 4'b0000, 4'b0010, 4'b0000, 4'b0000, rp(0,0,5,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0010, 4'b0000, 4'b0000, rp(0,0,4,0));
    add(4'b0010, md4(0,0,0,0), 4'b0010, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    add(4'b0010, md4(0,0,3,0), 4'b0000, 4'b0000, 4'b0000, 4'b0010, rp(0,0,0,0));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    // Mode 3 on a running channel: err pulses, count continues.
    add(4'b0001, md4(0,0,0,1), 4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,3));
    add(4'b0001, md4(0,0,0,3), 4'b0000, 4'b0001, 4'b0000, 4'b0001, rp(0,0,0,2));
    add(4'b0000, 8'h00,        4'b0000, 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,1));
    add(4'b0000, 8'h00,        4'b0000, 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0));
    // Abort beats completion on the same edge.
    add(4'b0010, md4(0,0,2,0), 4'b0000, 4'b0010, 4'b0000, 4'b0000, rp(0,0,1,0));
    add(4'b0000, 8'h00,        4'b0010, 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_we   = vecs[i].we;
      cfg_ch   = vecs[i].ch;
      cfg_mode = vecs[i].cm;
      cfg_val  = vecs[i].val;
      cyc(vecs[i].st, vecs[i].md, vecs[i].ab, 1'b0);
      check($sformatf("vec%0d", i), vecs[i].eb, vecs[i].ed, vecs[i].ee, vecs[i].er);
    end

    // Pause: ch0 holds at 2; ch2 is loaded during pause and also holds.
    cyc(4'b0001, md4(0,0,0,0), 4'b0000, 1'b0);
    check("pause_load", 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,5));
    for (int n = 4; n >= 2; n--) begin
      cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
      check($sformatf("pause_pre%0d", n), 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,n));
    end
    cyc(4'b0000, 8'h00, 4'b0000, 1'b1);
    check("pause_hold1", 4'b0001, 4'b0000, 4'b0000, rp(0,0,0,2));
    cyc(4'b0100, md4(0,1,0,0), 4'b0000, 1'b1);
    check("pause_start", 4'b0101, 4'b0000, 4'b0000, rp(0,7,0,2));
    for (int n = 0; n < 2; n++) begin
      cyc(4'b0000, 8'h00, 4'b0000, 1'b1);
      check($sformatf("pause_hold%0d", n + 2), 4'b0101, 4'b0000, 4'b0000, rp(0,7,0,2));
    end
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("pause_resume", 4'b0101, 4'b0000, 4'b0000, rp(0,6,0,1));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("pause_done", 4'b0100, 4'b0001, 4'b0000, rp(0,5,0,0));
    cyc(4'b0000, 8'h00, 4'b0100, 1'b0);
    check("pause_abort", 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));

    // Asynchronous reset mid-count, then rewritten entries revert to defaults.
    cyc(4'b1111, md4(1,1,1,1), 4'b0000, 1'b0);
    check("all_run", 4'b1111, 4'b0000, 4'b0000, rp(3,7,3,3));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("all_dec", 4'b1111, 4'b0000, 4'b0000, rp(2,6,2,2));
    #3 reset = 1'b0;
    #1;
    check("async_reset", 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0));
    #2 reset = 1'b1;
    cyc(4'b1100, md4(0,1,0,0), 4'b0000, 1'b0);
    check("post_reset_load", 4'b1100, 4'b0000, 4'b0000, rp(5,3,0,0));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("post_reset_n1", 4'b1100, 4'b0000, 4'b0000, rp(4,2,0,0));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("post_reset_n2", 4'b1100, 4'b0000, 4'b0000, rp(3,1,0,0));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("post_reset_n3", 4'b1000, 4'b0100, 4'b0000, rp(2,0,0,0));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("post_reset_n4", 4'b1000, 4'b0000, 4'b0000, rp(1,0,0,0));
    cyc(4'b0000, 8'h00, 4'b0000, 1'b0);
    check("post_reset_n5", 4'b0000, 4'b1000, 4'b0000, rp(0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
